// File: rtl/juez_carriles.sv
// Judges drum-pad presses against falling notes on LANES lanes: per-lane hit windows,
// saturating score with combo multiplier, miss counting and game-over.
module juez_carriles #(
  parameter int LANES      = 5,
  parameter int POS_W      = 10,
  parameter int SCORE_W    = 13,
  parameter int TARGET_Y   = 410,
  parameter int WINDOW     = 16,
  parameter int MISS_LIMIT = 8,
  parameter int COMBO_STEP = 8,
  parameter int MAX_MULT   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [LANES-1:0]       botones,
  input  logic [LANES-1:0]       note_valid,
  input  logic [LANES*POS_W-1:0] note_y,
  output logic [SCORE_W-1:0]     score,
  output logic [7:0]             combo,
  output logic [2:0]             mult,
  output logic [3:0]             misses,
  output logic                   perdio,
  output logic [LANES-1:0]       leds
);

  localparam int CW    = $clog2(LANES + 1);
  localparam int SUM_W = SCORE_W + CW + 3;
  localparam logic [POS_W:0] WIN_LO   = (POS_W+1)'(TARGET_Y - WINDOW);
  localparam logic [POS_W:0] WIN_HI   = (POS_W+1)'(TARGET_Y + WINDOW);
  localparam logic [3:0]     MISS_MAX = 4'(MISS_LIMIT);
  localparam logic [2:0]     MULT_MAX = 3'(MAX_MULT);

  typedef enum logic [1:0] {WAIT, ARMED, DONE} laneState_t;
  typedef enum logic [1:0] {IDLE, PLAY, OVER} gameState_t;

  gameState_t       gameState;
  logic             enablePrev;
  logic [LANES-1:0] syncA, syncB, syncC, pressReg;
  logic [LANES-1:0] laneHit, laneMiss;
  logic             active, startGame;
  logic [CW-1:0]    hitCount, missCount;
  logic [SUM_W-1:0] scoreSum;
  logic [8:0]       comboSum, multStep;
  logic [CW+4:0]    missSum;
  logic [SCORE_W-1:0] scoreNext;
  logic [7:0]       comboNext;
  logic [3:0]       missesNext;
  logic [2:0]       multNext;

  assign startGame = (gameState == IDLE) && enable && !enablePrev;
  // Once the miss limit is reached the board freezes until the game-over state takes over.
  assign active    = (gameState == PLAY) && enable && (misses != MISS_MAX);
  assign perdio    = (gameState == OVER);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syncA    <= '0;
      syncB    <= '0;
      syncC    <= '0;
      pressReg <= '0;
    end else begin
      syncA    <= botones;
      syncB    <= syncA;
      syncC    <= syncB;
      pressReg <= syncB & ~syncC;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : gLane
      logic [POS_W:0] posY;
      logic           inWin, past, newNote, hit, miss;
      laneState_t     state, stateNext;

      assign posY    = {1'b0, note_y[gi*POS_W +: POS_W]};
      assign inWin   = note_valid[gi] && (posY >= WIN_LO) && (posY <= WIN_HI);
      assign past    = note_valid[gi] && (posY > WIN_HI);
      assign newNote = !note_valid[gi] || (posY < WIN_LO);

      always_comb begin
        stateNext = state;
        hit       = 1'b0;
        miss      = 1'b0;
        case (state)
          WAIT: begin
            miss = pressReg[gi] || past;
            if (past)       stateNext = DONE;
            else if (inWin) stateNext = ARMED;
          end
          ARMED: begin
            hit  = pressReg[gi];
            miss = !pressReg[gi] && past;
            if (pressReg[gi] || past) stateNext = DONE;
          end
          DONE: begin
            miss = pressReg[gi];
            if (newNote) stateNext = WAIT;
          end
          default: stateNext = WAIT;
        endcase
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)         state <= WAIT;
        else if (startGame) state <= WAIT;
        else if (active)    state <= stateNext;
      end

      assign laneHit[gi]  = hit;
      assign laneMiss[gi] = miss;
    end
  endgenerate

  always_comb begin
    hitCount  = '0;
    missCount = '0;
    for (int i = 0; i < LANES; i++) begin
      hitCount  += CW'(laneHit[i]);
      missCount += CW'(laneMiss[i]);
    end
  end

  assign scoreSum   = SUM_W'(score) + SUM_W'(hitCount) * SUM_W'(mult);
  assign scoreNext  = (scoreSum[SUM_W-1:SCORE_W] != '0) ? '1 : scoreSum[SCORE_W-1:0];
  assign comboSum   = 9'(combo) + 9'(hitCount);
  assign comboNext  = (missCount != '0) ? 8'd0 : (comboSum[8] ? 8'hFF : comboSum[7:0]);
  assign missSum    = (CW+5)'(misses) + (CW+5)'(missCount);
  assign missesNext = (missSum >= (CW+5)'(MISS_LIMIT)) ? MISS_MAX : missSum[3:0];
  assign multStep   = 9'(combo / 8'(COMBO_STEP)) + 9'd1;
  assign multNext   = (multStep > 9'(MAX_MULT)) ? MULT_MAX : multStep[2:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gameState  <= IDLE;
      enablePrev <= 1'b0;
      score      <= '0;
      combo      <= '0;
      mult       <= 3'd1;
      misses     <= '0;
      leds       <= '0;
    end else begin
      enablePrev <= enable;
      leds       <= '0;
      case (gameState)
        IDLE: begin
          if (startGame) begin
            gameState <= PLAY;
            score     <= '0;
            combo     <= '0;
            misses    <= '0;
            mult      <= 3'd1;
          end
        end
        PLAY: begin
          if (!enable)                gameState <= IDLE;
          else if (misses == MISS_MAX) gameState <= OVER;
          if (active) begin
            score  <= scoreNext;
            combo  <= comboNext;
            misses <= missesNext;
            mult   <= multNext;
            leds   <= laneHit;
          end
        end
        OVER: begin
          if (!enable) gameState <= IDLE;
        end
        default: gameState <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_juez_carriles.sv
// Directed bench for juez_carriles: hits, window edges, multiplier, game over,
// saturation and asynchronous reset.
module tb_juez_carriles;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [4:0]  botones;
  logic [4:0]  note_valid;
  logic [49:0] note_y;
  logic [12:0] score;
  logic [7:0]  combo;
  logic [2:0]  mult;
  logic [3:0]  misses;
  logic        perdio;
  logic [4:0]  leds;

  int tests = 0;
  int fails = 0;

  juez_carriles dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .botones    (botones),
    .note_valid (note_valid),
    .note_y     (note_y),
    .score      (score),
    .combo      (combo),
    .mult       (mult),
    .misses     (misses),
    .perdio     (perdio),
    .leds       (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    if (obs === exp) $display("[TB] ok %s = %0d", tag, obs);
  endtask

  task automatic setNote(input int lane, input int y);
    note_valid[lane] = 1'b1;
    note_y[lane*10 +: 10] = 10'(y);
  endtask

  // Place notes at y on every lane in mask, let them arm, press, and return at the result edge.
  task automatic hitLanes(input logic [4:0] mask, input int y);
    for (int i = 0; i < 5; i++) if (mask[i]) setNote(i, y);
    tick();
    tick();
    botones = mask;
    repeat (4) tick();
  endtask

  task automatic releaseAll();
    botones    = '0;
    note_valid = '0;
    repeat (4) tick();
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; botones = '0; note_valid = '0; note_y = '0;
    repeat (3) tick();
    chk("rst_score", score, 0);
    chk("rst_combo", combo, 0);
    chk("rst_mult", mult, 1);
    chk("rst_misses", misses, 0);
    chk("rst_perdio", perdio, 0);
    chk("rst_leds", leds, 0);
    reset = 1'b1;
    tick();
    enable = 1'b1;
    tick();
    tick();

    // Single hit on lane 2 with latency check
    setNote(2, 410);
    tick();
    tick();
    botones = 5'b00100;
    repeat (3) tick();
    chk("hit_latency_k2", score, 0);
    tick();
    chk("hit_score", score, 1);
    chk("hit_combo", combo, 1);
    chk("hit_leds", leds, 5'b00100);
    tick();
    chk("hit_leds_oneshot", leds, 0);
    releaseAll();

    // Window edges
    hitLanes(5'b00001, 394);
    chk("edge394_score", score, 2);
    chk("edge394_combo", combo, 2);
    releaseAll();
    hitLanes(5'b00001, 426);
    chk("edge426_score", score, 3);
    releaseAll();
    hitLanes(5'b00001, 393);
    chk("bad393_misses", misses, 1);
    chk("bad393_combo", combo, 0);
    chk("bad393_score", score, 3);
    releaseAll();
    setNote(0, 427);
    tick();
    chk("late427_misses", misses, 2);
    repeat (3) tick();
    chk("late427_once", misses, 2);
    releaseAll();

    // Multiplier ramp on lane 1
    for (int n = 1; n <= 33; n++) begin
      hitLanes(5'b00010, 410);
      if (n == 9) chk("mult_hit9_score", score, 13);
      releaseAll();
      if (n == 8) begin
        chk("mult_after8", mult, 2);
        chk("score_after8", score, 11);
      end
      if (n == 32) begin
        chk("mult_after32", mult, 4);
        chk("score_after32", score, 83);
      end
      if (n == 33) begin
        chk("mult_after33", mult, 4);
        chk("score_after33", score, 87);
      end
    end
    botones = 5'b00010;
    repeat (4) tick();
    chk("miss_combo", combo, 0);
    chk("miss_misses", misses, 3);
    chk("miss_mult_lag", mult, 4);
    tick();
    chk("miss_mult_next", mult, 1);
    releaseAll();

    // Simultaneous lanes
    hitLanes(5'b10001, 410);
    chk("simul_score", score, 89);
    chk("simul_combo", combo, 2);
    chk("simul_leds", leds, 5'b10001);
    releaseAll();
    setNote(0, 410);
    setNote(4, 410);
    tick();
    tick();
    botones = 5'b10011;
    repeat (4) tick();
    chk("simulmiss_score", score, 91);
    chk("simulmiss_combo", combo, 0);
    chk("simulmiss_misses", misses, 4);
    releaseAll();

    // Game over via late misses (4 + 5 saturates at 8)
    for (int i = 0; i < 5; i++) setNote(i, 427);
    tick();
    chk("over_misses_sat", misses, 8);
    chk("over_perdio_same", perdio, 0);
    tick();
    chk("over_perdio", perdio, 1);
    releaseAll();
    hitLanes(5'b00100, 410);
    chk("over_score_frozen", score, 91);
    chk("over_leds", leds, 0);
    releaseAll();
    enable = 1'b0;
    tick();
    tick();
    chk("idle_score_held", score, 91);
    chk("idle_perdio", perdio, 0);
    enable = 1'b1;
    tick();
    chk("restart_score", score, 0);
    chk("restart_combo", combo, 0);
    chk("restart_misses", misses, 0);
    chk("restart_mult", mult, 1);

    // Enable dropped mid-press
    hitLanes(5'b11111, 410);
    chk("five_hit_score", score, 5);
    releaseAll();
    setNote(3, 410);
    tick();
    tick();
    botones = 5'b01000;
    tick();
    tick();
    enable = 1'b0;
    repeat (3) tick();
    chk("drop_score", score, 5);
    chk("drop_combo", combo, 5);
    chk("drop_leds", leds, 0);
    botones = '0;
    note_valid = '0;
    repeat (2) tick();
    enable = 1'b1;
    tick();
    chk("drop_restart_score", score, 0);
    tick();

    // Preload toward saturation: 5+5+10+10+15 then +20 each
    for (int p = 1; p <= 412; p++) begin
      hitLanes(5'b11111, 410);
      releaseAll();
    end
    chk("preload_score", score, 8185);
    chk("preload_mult", mult, 4);
    chk("combo_sat", combo, 255);
    hitLanes(5'b00001, 410);
    chk("near_sat_score", score, 8189);
    releaseAll();
    hitLanes(5'b11111, 410);
    chk("sat_score", score, 8191);
    chk("sat_leds", leds, 5'b11111);

    // Asynchronous reset while pads held, between clock edges
    #2;
    reset = 1'b0;
    #1;
    chk("arst_score", score, 0);
    chk("arst_combo", combo, 0);
    chk("arst_mult", mult, 1);
    chk("arst_misses", misses, 0);
    chk("arst_perdio", perdio, 0);
    chk("arst_leds", leds, 0);
    reset = 1'b1;
    botones = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/juez_carriles.md
# juez_carriles

Parametrised successor to the fixed 4-lane scorer: judges drum-pad presses against falling notes on `LANES` lanes. Each lane has a configurable hit window around the strike line. The block keeps a saturating score with a combo multiplier, counts misses, and raises `perdio` at a miss limit. It sits between the `Tubo` lane instances (note positions) and the score display chain (`PuntuacionTotal` / `DoubleDabbing`), all on the `clk50` domain.

## Interface
- `LANES`, default 5, number of note lanes/pads.
- `POS_W`, default 10, width of a note Y position.
- `SCORE_W`, default 13, score width.
- `TARGET_Y`, default 410, strike-line Y.
- `WINDOW`, default 16, half-width of the hit window in pixels.
- `MISS_LIMIT`, default 8, misses that end the game.
- `COMBO_STEP`, default 8, consecutive hits per multiplier step.
- `MAX_MULT`, default 4, multiplier ceiling (≤7).

Ports:
- `clk`, in, 1: system clock (`clk50`).
- `reset`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: game running (level).
- `botones`, in, `LANES`: raw pad inputs, asynchronous.
- `note_valid`, in, `LANES`: lane currently has a note on screen.
- `note_y`, in, `LANES*POS_W`: lane i position at bits [i*POS_W +: POS_W].
- `score`, out, `SCORE_W`: accumulated score.
- `combo`, out, 8: consecutive-hit count.
- `mult`, out, 3: current multiplier.
- `misses`, out, 4: miss count.
- `perdio`, out, 1: game over.
- `leds`, out, `LANES`: one-cycle per-lane hit strobe.

## Operation
- Pads pass through a 2-flop synchroniser, then a rising-edge detect. Only the edge counts, so holding a pad scores once.
- Window test per lane: `in_win` = `note_valid` & `TARGET_Y-WINDOW ≤ y ≤ TARGET_Y+WINDOW`. `past` = `note_valid` & `y > TARGET_Y+WINDOW`. Compare at `POS_W+1` bits, so there is no wrap.
- Per-lane FSM with states WAIT, ARMED, DONE:
  - WAIT→ARMED when `in_win`.
  - ARMED→DONE on a press (hit).
  - ARMED→DONE on `past` (late miss).
  - DONE→WAIT when `!note_valid` or `y < TARGET_Y-WINDOW` (new note).
  - WAIT→DONE on `past`. A note that skips the window is counted as a miss.
- Press in WAIT or DONE is a bad press and counts as a miss. A press in ARMED is a hit.
- Global FSM with states IDLE, PLAY, OVER:
  - IDLE→PLAY on `enable` rising. This clears score, combo, misses, lane FSMs, and sets mult=1.
  - PLAY→OVER when `misses` reaches `MISS_LIMIT`.
  - PLAY or OVER→IDLE on `enable` low. Outputs hold their values in IDLE.
  - Scoring and lane FSMs are active only in PLAY.
- Per-cycle update in PLAY, with `H` = hits this cycle and `M` = misses this cycle:
  - `score += H*mult`, using `mult` as registered at cycle start. Saturates at 2^SCORE_W−1.
  - If M>0: combo←0, misses += M, saturating at `MISS_LIMIT`.
  - Else: combo += H, saturating at 255.
  - Hits in the same cycle still score, even when a miss occurs.
- `mult` = min(1 + combo/COMBO_STEP, MAX_MULT), registered one cycle after combo.
- `perdio` = (state==OVER).

## Timing
- Reset values: score=0, combo=0, mult=1, misses=0, perdio=0, leds=0, all lane FSMs WAIT, global FSM IDLE.
- Pad edge: a pad rising between edges k−1 and k is detected at edge k+2. Score, combo, misses and leds update at edge k+3. `mult` follows combo at edge k+4.
- `leds[i]` is high exactly one cycle per hit.
- `perdio` asserts the cycle after `misses` reaches `MISS_LIMIT`.
- When `reset` is asserted mid-game, all outputs take their reset values immediately, without waiting for a clock edge.
- When `enable` falls mid-press, the press is dropped and no output changes.

## Test plan
- Hit: note y=410 in lane 2, press lane 2 → score 0→1, combo=1, leds=5'b00100 for 1 cycle, latency 3 clocks from the pad edge.
- Window edges: y=394 and y=426 → hit. y=393 → bad press (misses=1, combo=0). y=427 → miss counted on entry to `past`, with no press.
- Multiplier: 8 consecutive hits → mult=2, 9th hit adds 2. After 32 hits mult stays 4. One miss → combo=0 and mult=1 on the next cycle.
- Simultaneous: lanes 0 and 4 both in window, pressed in the same cycle, mult=1 → score +2, combo +2. A miss on lane 1 in that same cycle → score +2, combo=0, misses +1.
- Game over: 8 late misses → `perdio`=1. Presses afterwards leave score unchanged. `enable` low then high → score, combo and misses are 0, `perdio`=0.
- Saturation and reset: preload near 8190 with mult=4, hit → score=8191. Pulse `reset` low mid-hold → all outputs at reset values without a clock edge.
